ddr_burst_arb: RTL and testbench
================================

DDR_BURST_ARB -- requirements
Module: ddr_burst_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, meaning DDR address width {bank,row,column}.
REQ-002 SHALL have parameter LEN_W, default 10, meaning burst length width.
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning watchdog limit in clk_ref cycles for one burst.
REQ-004 SHALL have port clk_ref, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ddr_init_done, input, 1, DDR initialisation complete.
REQ-007 SHALL have port ch_req, input, 4, burst request per channel: ch0/ch1 are write, ch2/ch3 are read.
REQ-008 SHALL have port ch_addr, input, 4*ADDR_W, start address per channel, channel n at bits [n*ADDR_W +: ADDR_W].
REQ-009 SHALL have port ch_len, input, 4*LEN_W, burst length per channel, packed the same way.
REQ-010 SHALL have port ch_grant, output, 4, one-hot grant, held from the latch cycle until burst end.
REQ-011 SHALL have port ch_done, output, 4, one-cycle pulse on the granted bit at burst end.
REQ-012 SHALL have port ddr_wr_req / ddr_rd_req, output, 1 each, request to the DDR controller.
REQ-013 SHALL have port ddr_addr, output, ADDR_W, latched burst address.
REQ-014 SHALL have port ddr_len, output, LEN_W, latched burst length.
REQ-015 SHALL have port ddr_wr_ack / ddr_rd_ack, input, 1 each, first-word acknowledge.
REQ-016 SHALL have port ddr_wr_finish / ddr_rd_finish, input, 1 each, burst completion.
REQ-017 SHALL have port err_timeout, output, 1, one-cycle pulse on watchdog expiry.
REQ-018 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-019 SHALL implement the FSM IDLE -> LATCH -> ISSUE -> WAIT -> IDLE.
REQ-020 SHALL leave IDLE only when ddr_init_done=1 and ch_req!=0; otherwise it stays in IDLE.
REQ-021 In IDLE, SHALL pick the winner round-robin starting at pointer rr_ptr and scanning upward modulo 4, with ties broken by that scan order.
REQ-022 In LATCH (1 cycle), SHALL register the winner's ch_addr and ch_len into ddr_addr and ddr_len and set ch_grant; later input changes have no effect.
REQ-023 In ISSUE, SHALL assert ddr_wr_req for ch0/1 or ddr_rd_req for ch2/3 and hold it until the matching ack; it goes to WAIT on the cycle after the ack, with req deasserted.
REQ-024 If the ack and finish arrive in the same cycle, SHALL treat it as completion: ch_done pulses and the FSM goes to IDLE.
REQ-025 In WAIT, on the matching finish, SHALL pulse ch_done[winner] for 1 cycle, clear ch_grant, set rr_ptr=winner+1 mod 4, and go to IDLE.
REQ-026 SHALL ignore a non-matching ack or finish (e.g. rd_finish during a write burst).
REQ-027 SHALL ensure ddr_wr_req and ddr_rd_req are never both high, and ch_grant is never more than one-hot.
REQ-028 SHALL run a watchdog counter that clears on LATCH and counts in ISSUE and WAIT; at TIMEOUT-1 it pulses err_timeout, drops req and grant, does not pulse ch_done, leaves rr_ptr=winner+1, and returns to IDLE.
REQ-029 SHALL give a minimum request-to-ddr_req latency of 2 cycles (IDLE sample, LATCH).
REQ-030 If ddr_init_done falls mid-burst, SHALL let the current burst finish; arbitration is then blocked.
REQ-031 ch_len=0 is a legal burst length; SHALL pass it through unchanged.

Reset
REQ-032 On rst=1 at a clk_ref edge, SHALL set state=IDLE, rr_ptr=0, watchdog=0, and all outputs to 0 (ddr_addr, ddr_len, ch_grant, ch_done, both req, err_timeout, busy).
REQ-033 Reset mid-burst SHALL abandon the burst with no ch_done pulse.

Configuration
REQ-034 With DDR_ARB_WR_PRIO_EN defined, SHALL win any pending write channel (ch0/ch1, round-robin between the two) over all reads, and read channels SHALL round-robin only when no write is pending.
REQ-035 Without DDR_ARB_WR_PRIO_EN, SHALL use pure 4-way round-robin per REQ-021.

Verification
REQ-036 Test: rst then ch_req=4'b0001, addr=0x100, len=256, ack after 3 cycles, finish 256 later -> ddr_wr_req high for 3 cycles, ddr_addr=0x100, ch_done[0] pulses once.
REQ-037 Test: ch_req=4'b1111 held, default build -> grants ch0, ch1, ch2, ch3, ch0 in that order.
REQ-038 Test: same stimulus with DDR_ARB_WR_PRIO_EN -> grants alternate ch0, ch1 only; ch2 is granted after ch0/ch1 requests drop.
REQ-039 Test: TIMEOUT=16, no finish -> err_timeout pulses 16 cycles after LATCH, both reqs are 0, no ch_done, and the next grant goes to the next channel.
REQ-040 Test: rst asserted during WAIT -> next cycle all outputs 0; ddr_init_done=0 with ch_req=4'b0100 -> busy stays 0.

Source files
------------

// File: rtl/ddr_burst_arb_if.sv
// rtl/ddr_burst_arb_if.sv - channel and DDR-controller signal bundle for ddr_burst_arb
interface ddr_burst_arb_if #(
  parameter int ADDR_W = 25,
  parameter int LEN_W  = 10
);
  logic [3:0]          ch_req;
  logic [4*ADDR_W-1:0] ch_addr;
  logic [4*LEN_W-1:0]  ch_len;
  logic [3:0]          ch_grant;
  logic [3:0]          ch_done;
  logic                ddr_wr_req;
  logic                ddr_rd_req;
  logic [ADDR_W-1:0]   ddr_addr;
  logic [LEN_W-1:0]    ddr_len;
  logic                ddr_wr_ack;
  logic                ddr_rd_ack;
  logic                ddr_wr_finish;
  logic                ddr_rd_finish;

  // Environment side: requesting channels plus the DDR controller
  modport master (
    output ch_req, ch_addr, ch_len,
    output ddr_wr_ack, ddr_rd_ack, ddr_wr_finish, ddr_rd_finish,
    input  ch_grant, ch_done, ddr_wr_req, ddr_rd_req, ddr_addr, ddr_len
  );

  // Arbiter side
  modport slave (
    input  ch_req, ch_addr, ch_len,
    input  ddr_wr_ack, ddr_rd_ack, ddr_wr_finish, ddr_rd_finish,
    output ch_grant, ch_done, ddr_wr_req, ddr_rd_req, ddr_addr, ddr_len
  );
endinterface

// File: rtl/ddr_burst_arb.sv
// rtl/ddr_burst_arb.sv - 4-channel DDR burst arbiter; optional DDR_ARB_WR_PRIO_EN gives writes priority
module ddr_burst_arb #(
  parameter int ADDR_W  = 25,
  parameter int LEN_W   = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk_ref,
  input  logic           rst,
  input  logic           ddr_init_done,
  ddr_burst_arb_if.slave bus,
  output logic           err_timeout,
  output logic           busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [1:0]      rr_ptr;
  logic [1:0]      winner;
  logic [1:0]      pick;
  logic [3:0]      cand;
  logic [WD_W-1:0] wd;
  logic            is_wr;
  logic            ack;
  logic            fin;
  logic            wd_exp;

  // ch0/ch1 are write channels, ch2/ch3 read; only the matching ack/finish counts
  assign busy   = (state != S_IDLE);
  assign is_wr  = ~winner[1];
  assign ack    = is_wr ? bus.ddr_wr_ack : bus.ddr_rd_ack;
  assign fin    = is_wr ? bus.ddr_wr_finish : bus.ddr_rd_finish;
  assign wd_exp = (wd == WD_LAST);

  // Candidate set, then first requester scanning upward from rr_ptr modulo 4
  always_comb begin
    cand = bus.ch_req;
`ifdef DDR_ARB_WR_PRIO_EN
    if (bus.ch_req[1:0] != 2'b00) cand = {2'b00, bus.ch_req[1:0]};
`endif
    pick = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (cand[rr_ptr + 2'(i)]) pick = rr_ptr + 2'(i);
    end
  end

  // Burst sequencer: IDLE -> LATCH -> ISSUE -> WAIT -> IDLE, with watchdog abort
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state          <= S_IDLE;
      rr_ptr         <= 2'd0;
      winner         <= 2'd0;
      wd             <= '0;
      err_timeout    <= 1'b0;
      bus.ch_grant   <= 4'b0000;
      bus.ch_done    <= 4'b0000;
      bus.ddr_wr_req <= 1'b0;
      bus.ddr_rd_req <= 1'b0;
      bus.ddr_addr   <= '0;
      bus.ddr_len    <= '0;
    end else begin
      bus.ch_done <= 4'b0000;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ddr_init_done && (bus.ch_req != 4'b0000)) begin
            winner <= pick;
            state  <= S_LATCH;
          end
        end
        S_LATCH: begin
          // Payload captured once here; later input changes are ignored
          bus.ddr_addr   <= bus.ch_addr[int'(winner)*ADDR_W +: ADDR_W];
          bus.ddr_len    <= bus.ch_len[int'(winner)*LEN_W +: LEN_W];
          bus.ch_grant   <= 4'b0001 << winner;
          bus.ddr_wr_req <= is_wr;
          bus.ddr_rd_req <= ~is_wr;
          wd             <= '0;
          state          <= S_ISSUE;
        end
        S_ISSUE, S_WAIT: begin
          if (fin && ((state == S_WAIT) || ack)) begin
            // Normal completion; ack+finish together also lands here
            bus.ch_done    <= bus.ch_grant;
            bus.ch_grant   <= 4'b0000;
            bus.ddr_wr_req <= 1'b0;
            bus.ddr_rd_req <= 1'b0;
            rr_ptr         <= winner + 2'd1;
            state          <= S_IDLE;
          end else if (wd_exp) begin
            // Watchdog abort: no ch_done, rotation still advances past the winner
            err_timeout    <= 1'b1;
            bus.ch_grant   <= 4'b0000;
            bus.ddr_wr_req <= 1'b0;
            bus.ddr_rd_req <= 1'b0;
            rr_ptr         <= winner + 2'd1;
            state          <= S_IDLE;
          end else begin
            wd <= wd + 1'b1;
            if ((state == S_ISSUE) && ack) begin
              bus.ddr_wr_req <= 1'b0;
              bus.ddr_rd_req <= 1'b0;
              state          <= S_WAIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_burst_arb.sv
// tb/tb_ddr_burst_arb.sv - scoreboard bench for ddr_burst_arb with a round-robin reference model
module tb_ddr_burst_arb;
  localparam int AW = 25;
  localparam int LW = 10;
  localparam int TO = 300;

  logic clk = 1'b0;
  logic rst;
  logic init_done;
  logic err_timeout;
  logic busy;

  always #5 clk = ~clk;

  ddr_burst_arb_if #(.ADDR_W(AW), .LEN_W(LW)) bus();

  ddr_burst_arb #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk_ref      (clk),
    .rst          (rst),
    .ddr_init_done(init_done),
    .bus          (bus),
    .err_timeout  (err_timeout),
    .busy         (busy)
  );

  typedef struct {
    int          ch;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } grant_t;

  typedef struct {
    bit is_to;
    int ch;
  } out_t;

  grant_t grant_q[$];
  out_t   out_q[$];
  int     req_q[$];

  int checks = 0;
  int failures = 0;
  int model_rr = 0;
  int cur_w = 0;
  int cyc = 0;
  int grant_cyc = 0;

  logic [AW-1:0] a_tab[4];
  logic [LW-1:0] l_tab[4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input longint act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d required=none", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: scan channels upward from the pointer, first eligible requester wins
  function automatic int model_pick(input logic [3:0] r, input int ptr);
`ifdef DDR_ARB_WR_PRIO_EN
    bit wr_pending;
    wr_pending = r[0] || r[1];
`endif
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (ptr + k) % 4;
`ifdef DDR_ARB_WR_PRIO_EN
      if (r[c] && (!wr_pending || c < 2)) return c;
`else
      if (r[c]) return c;
`endif
    end
    return -1;
  endfunction

  task automatic drive_req(input logic [3:0] r, input bit randp);
    grant_t g;
    if (randp) begin
      for (int i = 0; i < 4; i++) begin
        a_tab[i] = AW'($urandom);
        l_tab[i] = ($urandom_range(7) == 0) ? '0 : LW'($urandom);
      end
    end
    for (int i = 0; i < 4; i++) begin
      bus.ch_addr[i*AW +: AW] = a_tab[i];
      bus.ch_len[i*LW +: LW]  = l_tab[i];
    end
    bus.ch_req = r;
    if (r != 4'b0000) begin
      cur_w  = model_pick(r, model_rr);
      g.ch   = cur_w;
      g.addr = a_tab[cur_w];
      g.len  = l_tab[cur_w];
      grant_q.push_back(g);
    end
  endtask

  task automatic clear_ddr();
    bus.ddr_wr_ack    = 1'b0;
    bus.ddr_rd_ack    = 1'b0;
    bus.ddr_wr_finish = 1'b0;
    bus.ddr_rd_finish = 1'b0;
  endtask

  task automatic noise(input bit is_wr);
    logic n_ack, n_fin;
    n_ack = ($urandom_range(3) == 0);
    n_fin = ($urandom_range(3) == 0);
    if (is_wr) begin
      bus.ddr_rd_ack    = n_ack;
      bus.ddr_rd_finish = n_fin;
    end else begin
      bus.ddr_wr_ack    = n_ack;
      bus.ddr_wr_finish = n_fin;
    end
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!(bus.ddr_wr_req || bus.ddr_rd_req) && n < 50) begin
      tick();
      n++;
    end
    ok = (n < 50);
    if (!ok) fail_msg("req_wait_expired", n);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ddr_addr"}, bus.ddr_addr, 0);
    chk({tag, "_ddr_len"}, bus.ddr_len, 0);
    chk({tag, "_ch_grant"}, bus.ch_grant, 0);
    chk({tag, "_ch_done"}, bus.ch_done, 0);
    chk({tag, "_wr_req"}, bus.ddr_wr_req, 0);
    chk({tag, "_rd_req"}, bus.ddr_rd_req, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    model_rr = 0;
  endtask

  // One burst: ack after d req-high cycles, finish f cycles after ack (0 = with ack), or watchdog
  task automatic run_burst(input int d, input int f, input bit to, input logic [3:0] nreq, input bit randp);
    bit   ok, is_wr;
    int   w, n;
    out_t o;
    wait_req(ok);
    if (!ok) return;
    is_wr = bus.ddr_wr_req;
    w = cur_w;
    req_q.push_back(d);
    model_rr = (w + 1) % 4;
    drive_req(nreq, randp);
    for (int i = 1; i < d; i++) begin
      noise(is_wr);
      tick();
    end
    noise(is_wr);
    if (is_wr) bus.ddr_wr_ack = 1'b1; else bus.ddr_rd_ack = 1'b1;
    if (!to && f == 0) begin
      o.is_to = 1'b0;
      o.ch = w;
      out_q.push_back(o);
      if (is_wr) bus.ddr_wr_finish = 1'b1; else bus.ddr_rd_finish = 1'b1;
    end
    tick();
    clear_ddr();
    if (!to && f > 0) begin
      for (int i = 1; i < f; i++) begin
        noise(is_wr);
        tick();
      end
      clear_ddr();
      o.is_to = 1'b0;
      o.ch = w;
      out_q.push_back(o);
      if (is_wr) bus.ddr_wr_finish = 1'b1; else bus.ddr_rd_finish = 1'b1;
      tick();
      clear_ddr();
    end
    if (to) begin
      o.is_to = 1'b1;
      o.ch = w;
      out_q.push_back(o);
    end
    n = 0;
    while (bus.ch_done == 4'b0000 && !err_timeout && n < TO + 20) begin
      tick();
      n++;
    end
    if (n >= TO + 20) fail_msg("burst_end_expired", n);
    tick();
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant, a req release, or a burst end
  logic [3:0] prev_grant = 4'b0000;
  bit         prev_req = 1'b0;
  int         req_cnt = 0;
  grant_t     mg;
  out_t       mo;
  int         mr;
  bit         cur_req;

  always @(negedge clk) begin
    cyc++;
    chk("req_exclusive", bus.ddr_wr_req & bus.ddr_rd_req, 0);
    chk("grant_onehot0", $onehot0(bus.ch_grant), 1);
    if (bus.ch_grant != 4'b0000 && prev_grant == 4'b0000) begin
      grant_cyc = cyc;
      if (grant_q.size() == 0) fail_msg("unexpected_grant", bus.ch_grant);
      else begin
        mg = grant_q.pop_front();
        chk("grant", bus.ch_grant, 1 << mg.ch);
        chk("ddr_addr", bus.ddr_addr, mg.addr);
        chk("ddr_len", bus.ddr_len, mg.len);
        chk("wr_req_type", bus.ddr_wr_req, (mg.ch < 2) ? 1 : 0);
        chk("rd_req_type", bus.ddr_rd_req, (mg.ch >= 2) ? 1 : 0);
      end
    end
    cur_req = bus.ddr_wr_req | bus.ddr_rd_req;
    if (cur_req) req_cnt++;
    else if (prev_req) begin
      if (req_q.size() == 0) fail_msg("unexpected_req_release", req_cnt);
      else begin
        mr = req_q.pop_front();
        chk("req_high_cycles", req_cnt, mr);
      end
      req_cnt = 0;
    end
    if (bus.ch_done != 4'b0000 || err_timeout) begin
      if (out_q.size() == 0) fail_msg("unexpected_burst_end", bus.ch_done);
      else begin
        mo = out_q.pop_front();
        chk("ch_done", bus.ch_done, mo.is_to ? 0 : (1 << mo.ch));
        chk("err_timeout", err_timeout, mo.is_to ? 1 : 0);
        chk("end_grant_clear", bus.ch_grant, 0);
        chk("end_req_clear", cur_req, 0);
        if (mo.is_to) chk("timeout_latency", cyc - grant_cyc, TO);
      end
    end
    prev_grant = bus.ch_grant;
    prev_req = cur_req;
  end

  initial begin
    #1000000;
    fail_msg("global_time_limit", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

  initial begin
    bit ok;
    int n_to;
    rst = 1'b1;
    init_done = 1'b1;
    bus.ch_req = 4'b0000;
    bus.ch_addr = '0;
    bus.ch_len = '0;
    clear_ddr();
    for (int i = 0; i < 4; i++) begin
      a_tab[i] = '0;
      l_tab[i] = '0;
    end
    reset_dut();

    // Single write burst: addr 0x100, len 256, ack on 3rd req cycle, finish 256 later
    a_tab[0] = AW'(32'h100);
    l_tab[0] = LW'(256);
    drive_req(4'b0001, 1'b0);
    run_burst(3, 256, 1'b0, 4'b0000, 1'b0);

    // Reset while in WAIT abandons the burst
    drive_req(4'b0010, 1'b1);
    wait_req(ok);
    if (ok) begin
      req_q.push_back(1);
      drive_req(4'b0000, 1'b0);
      if (bus.ddr_wr_req) bus.ddr_wr_ack = 1'b1; else bus.ddr_rd_ack = 1'b1;
      tick();
      clear_ddr();
      tick();
      chk("wait_grant_held", bus.ch_grant, 4'b0010);
      rst = 1'b1;
      tick();
      check_zero("mid_burst_reset");
      rst = 1'b0;
      model_rr = 0;
      repeat (5) tick();
    end

    // Arbitration blocked until DDR init completes
    init_done = 1'b0;
    drive_req(4'b0100, 1'b1);
    repeat (10) begin
      tick();
      chk("gated_busy", busy, 0);
      chk("gated_grant", bus.ch_grant, 0);
    end
    init_done = 1'b1;
    run_burst(2, 3, 1'b0, 4'b0000, 1'b0);

    // All four requesting continuously, then writes drop
    reset_dut();
    drive_req(4'b1111, 1'b1);
    for (int k = 0; k < 5; k++)
      run_burst($urandom_range(1, 4), $urandom_range(0, 6), 1'b0, (k < 4) ? 4'b1111 : 4'b1100, 1'b1);
    run_burst(2, 2, 1'b0, 4'b0000, 1'b1);

    // Watchdog expiry, then randomized traffic
    drive_req(4'($urandom_range(1, 15)), 1'b1);
    run_burst(2, 0, 1'b1, 4'($urandom_range(1, 15)), 1'b1);
    n_to = 0;
    for (int k = 0; k < 40; k++) begin
      bit t;
      t = (n_to < 2) && ($urandom_range(11) == 0);
      if (t) n_to++;
      run_burst($urandom_range(1, 5), $urandom_range(0, 12), t,
                (k == 39) ? 4'b0000 : 4'($urandom_range(1, 15)), 1'b1);
    end

    repeat (10) tick();
    chk("grant_q_drained", grant_q.size(), 0);
    chk("out_q_drained", out_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
